reg_file_ctrl: RTL and testbench
================================

# reg_file_ctrl

Multi-cycle instruction sequencer that drives the write port and both read ports of the 8×16 register file (`reg_file`). It accepts one 16-bit instruction per valid/ready handshake, reads its source registers, computes a 16-bit ALU result, and writes the result back. It also keeps carry and zero flags. It sits between the instruction source and the register file and is the only master of the register-file port.

## Interface
- No parameters. The data width is fixed at 16 bits and there are 8 registers with 3-bit addresses.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high.
- instr_valid  input  1  instruction present on `instr`.
- instr_ready  output  1  controller can accept an instruction.
- instr  input  16  instruction word: [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [8:0] imm9.
- rd_addr_a  output  3  register-file read address A. Equals the latched rs1.
- rd_addr_b  output  3  register-file read address B. Equals the latched rs2.
- d_out_a  input  16  register-file read data A (combinational from `rd_addr_a`).
- d_out_b  input  16  register-file read data B.
- wr  output  1  register-file write enable.
- wr_addr  output  3  register-file write address. Equals the latched rd.
- d_in  output  16  register-file write data. Equals the result register.
- done  output  1  one-cycle pulse when an instruction retires.
- err  output  1  one-cycle pulse, coincident with `done`, when the opcode is illegal.
- flag_c  output  1  carry/borrow flag.
- flag_z  output  1  zero flag.

## Operation
- States are IDLE, EXEC and WRITE. The reset state is IDLE.
- **IDLE:**
  - `instr_ready`=1.
  - When `instr_valid`=1, latch `instr` into the instruction register and go to EXEC.
  - Otherwise stay in IDLE.
- **EXEC:**
  - Addresses are driven from the latched fields. Compute from `d_out_a` (A) and `d_out_b` (B), register the result, and go to WRITE.
  - Opcode 0 NOP: no write.
  - Opcode 1 ADD: result = A+B. The carry candidate is bit 16 of the 17-bit sum.
  - Opcode 2 SUB: result = A−B (mod 2^16). The carry candidate is the borrow, which is 1 when A<B unsigned.
  - Opcode 3 AND, 4 OR, 5 XOR: bitwise operations.
  - Opcode 6 LDI: result = {7'b0, imm9}.
  - Opcode 7 MOV: result = A.
  - Opcodes 8–15 are illegal: no write, and `err` is raised.
- **WRITE:**
  - `wr`=1 only for opcodes 1–7. `wr_addr` = rd and `d_in` = result.
  - `done`=1, and `err`=1 when the opcode is illegal.
  - Go to IDLE.
- **Flags** update at the clock edge that ends WRITE, and only when `wr`=1:
  - `flag_z` = (result==0) for every write-back.
  - `flag_c` updates on ADD and SUB only. It holds its value on AND, OR, XOR, LDI and MOV.
  - NOP and illegal opcodes leave both flags unchanged.
- rd may equal rs1 or rs2. The register file is read in EXEC and written in WRITE, so there is no hazard.
- `instr` and `instr_valid` are ignored outside IDLE. The source must hold `instr_valid` until the handshake.

## Timing
- **Reset values:**
  - Outputs: `instr_ready`=1; `wr`, `done`, `err`, `flag_c`, `flag_z` = 0; `rd_addr_a`, `rd_addr_b`, `wr_addr` = 0; `d_in`=0.
  - Internal registers: instruction register and result register = 0.
- Handshake at edge T (IDLE, valid=1). The cycle after T is EXEC and the cycle after that is WRITE.
- Write latency: the register file captures the result at the edge ending WRITE, which is edge T+2. The new value is readable from cycle T+3.
- Throughput is one instruction per 3 cycles. If `instr_valid` stays high, `instr_ready` is high in every third cycle.
- `wr`, `done` and `err` are each high for exactly one cycle per instruction, all in the WRITE cycle. They are Moore outputs decoded from the state and the latched opcode.
- Reset asserted in any state:
  - Immediately forces IDLE and all reset values. `wr` drops without waiting for a clock edge.
  - The instruction in flight is discarded and no write occurs.
- Reset deasserted: the first handshake can occur at the first rising edge at which reset is low.

## Test plan
- **Loads:** LDI R1,0x005 then LDI R2,0x003.
  - Each produces `wr`=1 in its WRITE cycle, with `wr_addr`=1, `d_in`=0x0005, then `wr_addr`=2, `d_in`=0x0003.
  - `flag_z`=0 afterwards.
- **ADD:** ADD R3,R1,R2.
  - `rd_addr_a`=1 and `rd_addr_b`=2 during EXEC.
  - WRITE has `wr_addr`=3, `d_in`=0x0008. After retire, `flag_c`=0 and `flag_z`=0.
  - Register-file read of R3 = 0x0008 from cycle T+3.
- **SUB with borrow, then wrap:**
  - SUB R4,R2,R1 → `d_in`=0xFFFE, `flag_c`=1.
  - Then LDI R5,0x1FF, then XOR R6,R5,R5 → `d_in`=0x0000, `flag_z`=1, `flag_c` still 1.
- **Illegal opcode:** instr=0xF000.
  - `done`=1 and `err`=1 in WRITE, `wr`=0.
  - Register file and flags unchanged. The next instruction is accepted 3 cycles after the handshake.
- **Back-to-back:** hold `instr_valid`=1 with four instructions queued.
  - `instr_ready` is high at cycles 0, 3, 6, 9.
  - Exactly four `done` pulses and no `instr` sampling outside IDLE.
- **Reset mid-write:** assert reset asynchronously in the middle of an ADD's WRITE cycle.
  - `wr` and `done` drop immediately, the state returns to IDLE with `instr_ready`=1, and both flags are 0.
  - The register file, which shares this reset, reads all zeros.

Source files
------------

// File: rtl/reg_file_ctrl.sv
// Three-state sequencer (IDLE -> EXEC -> WRITE) that owns the 8x16 register-file ports:
// latches one instruction per handshake, runs the ALU on the read data, writes back, keeps C/Z flags.
module reg_file_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [2:0]  rd_addr_a,
  output logic [2:0]  rd_addr_b,
  input  logic [15:0] d_out_a,
  input  logic [15:0] d_out_b,
  output logic        wr,
  output logic [2:0]  wr_addr,
  output logic [15:0] d_in,
  output logic        done,
  output logic        err,
  output logic        flag_c,
  output logic        flag_z
);

  typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_LDI = 4'd6,
    OP_MOV = 4'd7
  } op_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q;
  logic [15:0] result_q;
  logic        carry_q;
  logic [3:0]  op;
  logic [15:0] alu_res;
  logic        alu_carry;
  logic [16:0] wide;

  assign op        = ir_q[15:12];
  assign rd_addr_a = ir_q[8:6];
  assign rd_addr_b = ir_q[5:3];
  assign wr_addr   = ir_q[11:9];
  assign d_in      = result_q;

  // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    wide      = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op)
      OP_ADD: begin
        wide      = {1'b0, d_out_a} + {1'b0, d_out_b};
        alu_res   = wide[15:0];
        alu_carry = wide[16];
      end
      OP_SUB: begin
        // Bit 16 of the extended difference is the unsigned borrow (A < B).
        wide      = {1'b0, d_out_a} - {1'b0, d_out_b};
        alu_res   = wide[15:0];
        alu_carry = wide[16];
      end
      OP_AND:  alu_res = d_out_a & d_out_b;
      OP_OR:   alu_res = d_out_a | d_out_b;
      OP_XOR:  alu_res = d_out_a ^ d_out_b;
      OP_LDI:  alu_res = {7'b0, ir_q[8:0]};
      OP_MOV:  alu_res = d_out_a;
      default: alu_res = '0;
    endcase
  end

  // Moore outputs: decoded from the state and the latched opcode only, so reset clears them at once.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    wr          = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = EXEC;
      end
      EXEC: state_d = WRITE;
      WRITE: begin
        done    = 1'b1;
        err     = op[3];
        wr      = ~op[3] && (op != OP_NOP);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ir_q     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && instr_valid) ir_q <= instr;
      if (state_q == EXEC) begin
        result_q <= alu_res;
        carry_q  <= alu_carry;
      end
      if (wr) begin
        flag_z <= (result_q == 16'h0000);
        if (op == OP_ADD || op == OP_SUB) flag_c <= carry_q;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Bench for reg_file_ctrl: behavioural register file, directed vector table, hand-written
// back-to-back and reset-in-WRITE sequences, then random instructions against an abstract model.
module tb_reg_file_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0] d_out_a, d_out_b, d_in;
  logic        wr, done, err, flag_c, flag_z;

  int n_tests = 0;
  int n_fail  = 0;

  reg_file_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .d_out_a(d_out_a),
    .d_out_b(d_out_b), .wr(wr), .wr_addr(wr_addr), .d_in(d_in), .done(done),
    .err(err), .flag_c(flag_c), .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  // Register file sharing the controller's reset.
  logic [15:0] rf [8];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (wr) begin
      rf[wr_addr] <= d_in;
    end
  end
  assign d_out_a = rf[rd_addr_a];
  assign d_out_b = rf[rd_addr_b];

  // Reference model state.
  logic [15:0] m_rf [8];
  bit          m_c, m_z;

  // Values observed during the last instruction.
  logic [2:0]  obs_ra, obs_rb, obs_waddr;
  logic [15:0] obs_din;
  logic        obs_wr, obs_done, obs_err, obs_c, obs_z, obs_ready_exec, obs_done_after;

  typedef struct {
    logic [15:0] ins;
    bit          wr;
    logic [15:0] din;
    bit          err;
    bit          c;
    bit          z;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_c = 0;
    m_z = 0;
  endtask

  // Architectural effect of one instruction, straight from the instruction-set rules.
  task automatic model_step(input logic [15:0] ins, output bit e_wr, output logic [15:0] e_res,
                            output bit e_err);
    int a, b, r;
    a = int'(m_rf[ins[8:6]]);
    b = int'(m_rf[ins[5:3]]);
    r = 0;
    e_wr = 1;
    e_err = 0;
    case (int'(ins[15:12]))
      0: e_wr = 0;
      1: begin r = a + b; m_c = (r > 65535); r = r % 65536; end
      2: begin m_c = (a < b); r = a - b; if (r < 0) r = r + 65536; end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = int'(ins[8:0]);
      7: r = a;
      default: begin e_wr = 0; e_err = 1; end
    endcase
    e_res = r[15:0];
    if (e_wr) begin
      m_rf[ins[11:9]] = r[15:0];
      m_z = (r == 0);
    end
  endtask

  // Issue one instruction and observe EXEC, WRITE and the cycle after.
  task automatic do_instr(input logic [15:0] ins);
    int n;
    @(negedge clk);
    n = 0;
    while (!instr_ready && n < 6) begin
      @(negedge clk);
      n++;
    end
    check("ready_in_idle", instr_ready, 1);
    instr = ins;
    instr_valid = 1;
    @(posedge clk); #1;
    instr_valid = 0;
    instr = 16'($urandom);
    @(negedge clk);
    obs_ra = rd_addr_a;
    obs_rb = rd_addr_b;
    obs_ready_exec = instr_ready;
    @(negedge clk);
    obs_wr = wr;
    obs_waddr = wr_addr;
    obs_din = d_in;
    obs_done = done;
    obs_err = err;
    @(posedge clk); #1;
    obs_c = flag_c;
    obs_z = flag_z;
    obs_done_after = done;
  endtask

  task automatic run_and_check(input logic [15:0] ins, input bit exp_wr, input logic [15:0] exp_din,
                               input bit exp_err, input bit exp_c, input bit exp_z);
    do_instr(ins);
    check("exec_rd_addr_a", obs_ra, ins[8:6]);
    check("exec_rd_addr_b", obs_rb, ins[5:3]);
    check("exec_ready_low", obs_ready_exec, 0);
    check("write_wr", obs_wr, exp_wr);
    check("write_wr_addr", obs_waddr, ins[11:9]);
    if (exp_wr) check("write_d_in", obs_din, exp_din);
    check("write_done", obs_done, 1);
    check("write_err", obs_err, exp_err);
    check("done_one_cycle", obs_done_after, 0);
    check("flag_c", obs_c, exp_c);
    check("flag_z", obs_z, exp_z);
    check("rf_dest", rf[ins[11:9]], m_rf[ins[11:9]]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          e_wr, e_err;
    logic [15:0] e_res;
    logic [15:0] b2b [4];
    int          idx, n_done;
    logic [15:0] ins;

    tbl[0]  = '{16'h6205, 1, 16'h0005, 0, 0, 0};  // LDI R1,5
    tbl[1]  = '{16'h6403, 1, 16'h0003, 0, 0, 0};  // LDI R2,3
    tbl[2]  = '{16'h1650, 1, 16'h0008, 0, 0, 0};  // ADD R3,R1,R2
    tbl[3]  = '{16'h2888, 1, 16'hFFFE, 0, 1, 0};  // SUB R4,R2,R1 (borrow)
    tbl[4]  = '{16'h6BFF, 1, 16'h01FF, 0, 1, 0};  // LDI R5,0x1FF
    tbl[5]  = '{16'h5D68, 1, 16'h0000, 0, 1, 1};  // XOR R6,R5,R5
    tbl[6]  = '{16'hF000, 0, 16'h0000, 1, 1, 1};  // illegal
    tbl[7]  = '{16'h0E3F, 0, 16'h0000, 0, 1, 1};  // NOP
    tbl[8]  = '{16'h7EC0, 1, 16'h0008, 0, 1, 0};  // MOV R7,R3
    tbl[9]  = '{16'h1120, 1, 16'hFFFC, 0, 1, 0};  // ADD R0,R4,R4 (carry out)
    tbl[10] = '{16'h1250, 1, 16'h0008, 0, 0, 0};  // ADD R1,R1,R2
    tbl[11] = '{16'h3488, 1, 16'h0000, 0, 0, 1};  // AND R2,R2,R1
    tbl[12] = '{16'h46D8, 1, 16'h0008, 0, 0, 0};  // OR R3,R3,R3
    tbl[13] = '{16'h2AD8, 1, 16'h0000, 0, 0, 1};  // SUB R5,R3,R3

    b2b[0] = 16'h6011;  // LDI R0,0x011
    b2b[1] = 16'h66AA;  // LDI R3,0x0AA
    b2b[2] = 16'h6D55;  // LDI R6,0x155
    b2b[3] = 16'h6FFE;  // LDI R7,0x1FE

    reset = 0;
    instr_valid = 0;
    instr = '0;
    #2 reset = 1;
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_wr", wr, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_flag_c", flag_c, 0);
    check("rst_flag_z", flag_z, 0);
    check("rst_rd_addr_a", rd_addr_a, 0);
    check("rst_rd_addr_b", rd_addr_b, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_d_in", d_in, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 14; i++) begin
      model_step(tbl[i].ins, e_wr, e_res, e_err);
      run_and_check(tbl[i].ins, tbl[i].wr, tbl[i].din, tbl[i].err, tbl[i].c, tbl[i].z);
    end
    check("r3_readback", rf[3], 16'h0008);
    check("r6_readback", rf[6], 16'h0000);

    // Back-to-back with instr_valid held high; garbage on instr outside IDLE.
    idx = 0;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("b2b_ready", instr_ready, (k % 3 == 0) ? 1 : 0);
      if (done) n_done++;
      if (k % 3 == 0 && idx < 4) begin
        instr = b2b[idx];
        model_step(b2b[idx], e_wr, e_res, e_err);
        idx++;
      end else begin
        instr = 16'($urandom);
      end
      instr_valid = 1;
    end
    instr_valid = 0;
    @(posedge clk); #1;
    check("b2b_done_count", n_done, 4);
    for (int i = 0; i < 8; i++) check("b2b_rf", rf[i], m_rf[i]);
    check("b2b_flag_z", flag_z, m_z);
    check("b2b_flag_c", flag_c, m_c);

    // Set C=1, Z=0, then reset in the middle of an ADD's WRITE cycle.
    model_step(16'h63FF, e_wr, e_res, e_err);
    run_and_check(16'h63FF, e_wr, e_res, e_err, m_c, m_z);
    model_step(16'h6400, e_wr, e_res, e_err);
    run_and_check(16'h6400, e_wr, e_res, e_err, m_c, m_z);
    model_step(16'h2888, e_wr, e_res, e_err);
    run_and_check(16'h2888, e_wr, e_res, e_err, m_c, m_z);
    check("pre_reset_flag_c", flag_c, 1);
    @(negedge clk);
    instr = 16'h1690;
    instr_valid = 1;
    @(posedge clk); #1;
    instr_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_wr", wr, 1);
    #2 reset = 1;
    #1;
    check("mid_reset_wr", wr, 0);
    check("mid_reset_done", done, 0);
    check("mid_reset_ready", instr_ready, 1);
    check("mid_reset_flag_c", flag_c, 0);
    check("mid_reset_flag_z", flag_z, 0);
    check("mid_reset_d_in", d_in, 0);
    for (int i = 0; i < 8; i++) check("mid_reset_rf", rf[i], 0);
    model_reset();

    // First handshake on the first edge after release.
    @(posedge clk); #1;
    instr = 16'h6233;
    instr_valid = 1;
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    instr_valid = 0;
    @(negedge clk);
    check("post_reset_handshake", instr_ready, 0);
    @(negedge clk);
    check("post_reset_wr", wr, 1);
    check("post_reset_d_in", d_in, 16'h0033);
    model_step(16'h6233, e_wr, e_res, e_err);
    @(posedge clk); #1;
    check("post_reset_rf", rf[1], m_rf[1]);

    // Random instructions against the model.
    for (int i = 0; i < 60; i++) begin
      ins = {4'($urandom_range(0, 9)), 12'($urandom)};
      model_step(ins, e_wr, e_res, e_err);
      run_and_check(ins, e_wr, e_res, e_err, m_c, m_z);
    end
    for (int i = 0; i < 8; i++) check("final_rf", rf[i], m_rf[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
